// File: rtl/rx78_cart_loader.sv
// Cartridge upload stage: turns the HPS ioctl byte stream into cartridge RAM writes and pads the tail.
// Optional RX78_CART_CHECKSUM_EN enables a 16-bit wrapping sum of the loaded bytes on cart_sum.
module rx78_cart_loader #(
  parameter logic [7:0] CART_INDEX = 8'd1,
  parameter int         ADDR_W     = 15,
  parameter logic [7:0] PAD_BYTE   = 8'hFF
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              ioctl_download,
  input  logic [7:0]        ioctl_index,
  input  logic              ioctl_wr,
  input  logic [24:0]       ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  output logic              ioctl_wait,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_din,
  output logic [ADDR_W:0]   cart_size,
  output logic              cart_valid,
  output logic              overflow,
  output logic [15:0]       cart_sum
);

  typedef enum logic [1:0] {IDLE, LOAD, PAD, DONE} state_t;

  localparam logic [ADDR_W:0] FULL = {1'b1, {ADDR_W{1'b0}}};

  state_t            state, state_nx;
  logic              dl_q;
  logic              sel, rise, fall, start, acc, drop;
  logic [ADDR_W:0]   addr_p1, size_nx;
  logic [ADDR_W-1:0] ptr;

  assign sel     = (ioctl_index == CART_INDEX);
  assign rise    = ioctl_download & ~dl_q;
  assign fall    = ~ioctl_download & dl_q;
  assign start   = rise && sel && (state != LOAD);
  assign acc     = (state == LOAD) && sel && ioctl_wr && ((ioctl_addr >> ADDR_W) == '0);
  assign drop    = (state == LOAD) && sel && ioctl_wr && ((ioctl_addr >> ADDR_W) != '0);
  assign addr_p1 = {1'b0, ioctl_addr[ADDR_W-1:0]} + (ADDR_W+1)'(1);
  // Includes a byte strobed in the same cycle as the falling edge
  assign size_nx = (acc && (addr_p1 > cart_size)) ? addr_p1 : cart_size;

  always_ff @(posedge clk_sys) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE, DONE: if (start) state_nx = LOAD;
      LOAD: begin
        if (fall) begin
          if (size_nx == '0)        state_nx = IDLE;
          else if (size_nx == FULL) state_nx = DONE;
          else                      state_nx = PAD;
        end
      end
      PAD: begin
        if (start)      state_nx = LOAD;
        else if (&ptr)  state_nx = DONE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    ioctl_wait = (state == PAD);
    cart_valid = (state == DONE);
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      dl_q      <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_din   <= '0;
      cart_size <= '0;
      overflow  <= 1'b0;
      ptr       <= '0;
    end else begin
      dl_q   <= ioctl_download;
      mem_we <= 1'b0;
      if (start) begin
        cart_size <= '0;
        overflow  <= 1'b0;
      end else if (state == LOAD) begin
        if (acc) begin
          mem_we    <= 1'b1;
          mem_addr  <= ioctl_addr[ADDR_W-1:0];
          mem_din   <= ioctl_dout;
          cart_size <= size_nx;
        end
        if (drop) overflow <= 1'b1;
        if (fall) ptr <= size_nx[ADDR_W-1:0];
      end else if (state == PAD) begin
        mem_we   <= 1'b1;
        mem_addr <= ptr;
        mem_din  <= PAD_BYTE;
        ptr      <= ptr + 1'b1;
      end
    end
  end

`ifdef RX78_CART_CHECKSUM_EN
  logic [15:0] sum_q;
  always_ff @(posedge clk_sys) begin
    if (reset)      sum_q <= '0;
    else if (start) sum_q <= '0;
    else if (acc)   sum_q <= sum_q + {8'h00, ioctl_dout};
  end
  assign cart_sum = sum_q;
`else
  assign cart_sum = '0;
`endif

endmodule

// File: tb/tb_rx78_cart_loader.sv
// Randomized bench for rx78_cart_loader against an array/queue model of the loaded cartridge image.
module tb_rx78_cart_loader;
  localparam int AW = 15;
  localparam int MSZ = 1 << AW;
`ifdef RX78_CART_CHECKSUM_EN
  localparam bit CSUM = 1'b1;
`else
  localparam bit CSUM = 1'b0;
`endif

  logic          clk_sys = 1'b0;
  logic          reset = 1'b1;
  logic          ioctl_download = 1'b0;
  logic [7:0]    ioctl_index = 8'd1;
  logic          ioctl_wr = 1'b0;
  logic [24:0]   ioctl_addr = '0;
  logic [7:0]    ioctl_dout = '0;
  logic          ioctl_wait, mem_we, cart_valid, overflow;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_din;
  logic [AW:0]   cart_size;
  logic [15:0]   cart_sum;

  int tests = 0, fails = 0;
  int we_cnt = 0, wait_cnt = 0;
  logic [7:0] emem [0:MSZ-1];
  logic [7:0] dmem [0:MSZ-1];

  rx78_cart_loader dut (
    .clk_sys(clk_sys), .reset(reset), .ioctl_download(ioctl_download),
    .ioctl_index(ioctl_index), .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr),
    .ioctl_dout(ioctl_dout), .ioctl_wait(ioctl_wait), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_din(mem_din), .cart_size(cart_size),
    .cart_valid(cart_valid), .overflow(overflow), .cart_sum(cart_sum)
  );

  always #5 clk_sys = ~clk_sys;

  // Observed memory image and strobe counters
  always @(negedge clk_sys) begin
    if (mem_we === 1'b1) begin
      dmem[mem_addr] <= mem_din;
      we_cnt <= we_cnt + 1;
    end
    if (ioctl_wait === 1'b1) wait_cnt <= wait_cnt + 1;
  end

  task automatic tick();
    @(posedge clk_sys); #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    tests++; if (mem_we !== 1'b0) begin fails++; $display("FAIL rst_we got %b exp 0", mem_we); end
    tests++; if (mem_addr !== '0 || mem_din !== '0) begin fails++; $display("FAIL rst_addr_din got %h/%h exp 0/0", mem_addr, mem_din); end
    tests++; if (cart_size !== '0) begin fails++; $display("FAIL rst_size got %h exp 0", cart_size); end
    tests++; if (cart_valid !== 1'b0 || overflow !== 1'b0 || ioctl_wait !== 1'b0) begin fails++; $display("FAIL rst_flags got v%b o%b w%b exp 000", cart_valid, overflow, ioctl_wait); end
    tests++; if (cart_sum !== 16'h0) begin fails++; $display("FAIL rst_sum got %h exp 0", cart_sum); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    logic [7:0] bv [4] = '{8'h3E, 8'h01, 8'hD3, 8'h00};
    logic [15:0] s = 0;
    int we0, wt0, n, bad;
    we0 = we_cnt; wt0 = wait_cnt;
    ioctl_index = 8'd1; ioctl_download = 1'b1;
    tick();
    tests++; if (cart_valid !== 1'b0 || cart_size !== '0) begin fails++; $display("FAIL basic_start got v%b sz%h exp 0/0", cart_valid, cart_size); end
    for (int i = 0; i < 4; i++) begin
      ioctl_wr = 1'b1; ioctl_addr = 25'(i); ioctl_dout = bv[i];
      emem[i] = bv[i]; s += {8'h00, bv[i]};
      tick();
      ioctl_wr = 1'b0;
      tests++; if (mem_we !== 1'b1 || mem_addr !== AW'(i) || mem_din !== bv[i]) begin fails++; $display("FAIL basic_wr%0d got we%b a%h d%h exp 1/%h/%h", i, mem_we, mem_addr, mem_din, i, bv[i]); end
      tick();
      tests++; if (mem_we !== 1'b0) begin fails++; $display("FAIL basic_pulse%0d got we%b exp 0", i, mem_we); end
    end
    for (int i = 4; i < MSZ; i++) emem[i] = 8'hFF;
    ioctl_download = 1'b0;
    tick();
    tests++; if (ioctl_wait !== 1'b1 || cart_size !== 16'd4) begin fails++; $display("FAIL basic_pad_start got w%b sz%h exp 1/4", ioctl_wait, cart_size); end
    n = 0;
    while (n < 40000 && cart_valid !== 1'b1) begin tick(); n++; end
    tests++; if (n !== 32764) begin fails++; $display("FAIL basic_pad_len got %0d exp 32764", n); end
    tests++; if (cart_valid !== 1'b1 || ioctl_wait !== 1'b0) begin fails++; $display("FAIL basic_done got v%b w%b exp 1/0", cart_valid, ioctl_wait); end
    tick(); tick();
    tests++; if (wait_cnt - wt0 !== 32764) begin fails++; $display("FAIL basic_wait_cnt got %0d exp 32764", wait_cnt - wt0); end
    tests++; if (we_cnt - we0 !== 32768) begin fails++; $display("FAIL basic_we_cnt got %0d exp 32768", we_cnt - we0); end
    tests++; if (cart_size !== 16'd4 || overflow !== 1'b0) begin fails++; $display("FAIL basic_size got %h o%b exp 4/0", cart_size, overflow); end
    tests++; if (cart_sum !== (CSUM ? s : 16'h0)) begin fails++; $display("FAIL basic_sum got %h exp %h", cart_sum, CSUM ? s : 16'h0); end
    bad = 0;
    for (int i = 0; i < MSZ; i++) if (dmem[i] !== emem[i]) bad++;
    tests++; if (bad !== 0) begin fails++; $display("FAIL basic_mem got %0d bad bytes exp 0", bad); end
  endtask

  task automatic test_full();
    logic [15:0] s = 0;
    logic [7:0] d;
    int we0, wt0, bad, mbad;
    we0 = we_cnt; wt0 = wait_cnt; bad = 0;
    ioctl_download = 1'b1;
    tick();
    for (int i = 0; i < MSZ; i++) begin
      d = 8'($urandom);
      ioctl_wr = 1'b1; ioctl_addr = 25'(i); ioctl_dout = d;
      emem[i] = d; s += {8'h00, d};
      tick();
      if (!(mem_we === 1'b1 && mem_addr === AW'(i) && mem_din === d)) bad++;
    end
    ioctl_wr = 1'b0; ioctl_download = 1'b0;
    tick();
    tests++; if (bad !== 0) begin fails++; $display("FAIL full_wr got %0d bad strobes exp 0", bad); end
    tests++; if (cart_valid !== 1'b1) begin fails++; $display("FAIL full_valid got %b exp 1", cart_valid); end
    tests++; if (cart_size !== 16'h8000 || overflow !== 1'b0) begin fails++; $display("FAIL full_size got %h o%b exp 8000/0", cart_size, overflow); end
    tick();
    tests++; if (wait_cnt !== wt0 || we_cnt - we0 !== MSZ) begin fails++; $display("FAIL full_cnt got wait%0d we%0d exp 0/%0d", wait_cnt - wt0, we_cnt - we0, MSZ); end
    tests++; if (cart_sum !== (CSUM ? s : 16'h0)) begin fails++; $display("FAIL full_sum got %h exp %h", cart_sum, CSUM ? s : 16'h0); end
    mbad = 0;
    for (int i = 0; i < MSZ; i++) if (dmem[i] !== emem[i]) mbad++;
    tests++; if (mbad !== 0) begin fails++; $display("FAIL full_mem got %0d bad bytes exp 0", mbad); end
  endtask

  task automatic test_foreign();
    int we0;
    we0 = we_cnt;
    ioctl_index = 8'd2; ioctl_download = 1'b1;
    tick();
    for (int i = 0; i < 100; i++) begin
      ioctl_wr = 1'b1; ioctl_addr = 25'($urandom_range(0, MSZ - 1)); ioctl_dout = 8'($urandom);
      tick();
    end
    ioctl_wr = 1'b0; ioctl_download = 1'b0;
    tick(); tick();
    tests++; if (we_cnt !== we0) begin fails++; $display("FAIL foreign_we got %0d strobes exp 0", we_cnt - we0); end
    tests++; if (cart_valid !== 1'b1 || cart_size !== 16'h8000 || ioctl_wait !== 1'b0) begin fails++; $display("FAIL foreign_keep got v%b sz%h w%b exp 1/8000/0", cart_valid, cart_size, ioctl_wait); end
    ioctl_index = 8'd1;
  endtask

  task automatic test_zero();
    int we0, wt0;
    we0 = we_cnt; wt0 = wait_cnt;
    ioctl_download = 1'b1;
    tick();
    tests++; if (cart_valid !== 1'b0) begin fails++; $display("FAIL zero_start got v%b exp 0", cart_valid); end
    ioctl_download = 1'b0;
    tick();
    tests++; if (cart_valid !== 1'b0 || ioctl_wait !== 1'b0 || cart_size !== '0) begin fails++; $display("FAIL zero_end got v%b w%b sz%h exp 0/0/0", cart_valid, ioctl_wait, cart_size); end
    repeat (3) tick();
    tests++; if (we_cnt !== we0 || wait_cnt !== wt0) begin fails++; $display("FAIL zero_idle got we%0d wait%0d exp 0/0", we_cnt - we0, wait_cnt - wt0); end
  endtask

  task automatic test_overflow_abort();
    logic [15:0] s = 0;
    logic [7:0] d;
    int p, k;
    p = $urandom_range(0, 16); k = 0;
    ioctl_download = 1'b1;
    tick();
    for (int j = 0; j < 17; j++) begin
      if (j == p) begin
        ioctl_wr = 1'b1; ioctl_addr = 25'h8000; ioctl_dout = 8'($urandom);
        tick();
        tests++; if (mem_we !== 1'b0) begin fails++; $display("FAIL ovf_drop got we%b exp 0", mem_we); end
      end else begin
        d = 8'($urandom);
        ioctl_wr = 1'b1; ioctl_addr = 25'(k); ioctl_dout = d; s += {8'h00, d};
        tick();
        tests++; if (mem_we !== 1'b1 || mem_addr !== AW'(k) || mem_din !== d) begin fails++; $display("FAIL ovf_wr%0d got we%b a%h d%h exp 1/%h/%h", k, mem_we, mem_addr, mem_din, k, d); end
        k++;
      end
    end
    ioctl_wr = 1'b0; ioctl_download = 1'b0;
    tick();
    tests++; if (overflow !== 1'b1 || cart_size !== 16'd16 || ioctl_wait !== 1'b1) begin fails++; $display("FAIL ovf_end got o%b sz%h w%b exp 1/10/1", overflow, cart_size, ioctl_wait); end
    tests++; if (cart_sum !== (CSUM ? s : 16'h0)) begin fails++; $display("FAIL ovf_sum got %h exp %h", cart_sum, CSUM ? s : 16'h0); end
    repeat (20) tick();
    ioctl_download = 1'b1;
    tick();
    tests++; if (ioctl_wait !== 1'b0 || cart_size !== '0 || overflow !== 1'b0 || cart_valid !== 1'b0) begin fails++; $display("FAIL abort_clear got w%b sz%h o%b v%b exp 0/0/0/0", ioctl_wait, cart_size, overflow, cart_valid); end
    tests++; if (cart_sum !== 16'h0) begin fails++; $display("FAIL abort_sum got %h exp 0", cart_sum); end
    tick();
    tests++; if (mem_we !== 1'b0) begin fails++; $display("FAIL abort_we got %b exp 0", mem_we); end
    ioctl_download = 1'b0;
    tick(); tick();
    tests++; if (ioctl_wait !== 1'b0 || cart_valid !== 1'b0) begin fails++; $display("FAIL abort_idle got w%b v%b exp 0/0", ioctl_wait, cart_valid); end
  endtask

  task automatic test_reset_in_pad();
    logic [15:0] s = 0;
    logic [AW:0] esz = 0;
    logic [7:0] d;
    int a, we0;
    ioctl_download = 1'b1;
    tick();
    for (int i = 0; i < 20; i++) begin
      a = $urandom_range(0, 63); d = 8'($urandom);
      ioctl_wr = 1'b1; ioctl_addr = 25'(a); ioctl_dout = d;
      if (i == 19) ioctl_download = 1'b0;
      if (a + 1 > int'(esz)) esz = (AW+1)'(a + 1);
      s += {8'h00, d};
      tick();
      tests++; if (mem_we !== 1'b1 || mem_addr !== AW'(a) || mem_din !== d) begin fails++; $display("FAIL rnd_wr%0d got we%b a%h d%h exp 1/%h/%h", i, mem_we, mem_addr, mem_din, a, d); end
    end
    ioctl_wr = 1'b0;
    tests++; if (ioctl_wait !== 1'b1 || cart_size !== esz) begin fails++; $display("FAIL rnd_size got w%b sz%h exp 1/%h", ioctl_wait, cart_size, esz); end
    tests++; if (cart_sum !== (CSUM ? s : 16'h0)) begin fails++; $display("FAIL rnd_sum got %h exp %h", cart_sum, CSUM ? s : 16'h0); end
    for (int k = 1; k < 10; k++) begin
      tick();
      tests++; if (mem_we !== 1'b1 || mem_addr !== AW'(int'(esz) + k - 1) || mem_din !== 8'hFF || ioctl_wait !== 1'b1) begin fails++; $display("FAIL pad_wr%0d got we%b a%h d%h w%b exp 1/%h/ff/1", k, mem_we, mem_addr, mem_din, ioctl_wait, int'(esz) + k - 1); end
    end
    reset = 1'b1;
    tick();
    tests++; if (mem_we !== 1'b0 || ioctl_wait !== 1'b0 || cart_valid !== 1'b0 || cart_size !== '0) begin fails++; $display("FAIL padrst got we%b w%b v%b sz%h exp 0/0/0/0", mem_we, ioctl_wait, cart_valid, cart_size); end
    reset = 1'b0;
    we0 = we_cnt;
    repeat (3) tick();
    tests++; if (we_cnt !== we0 || ioctl_wait !== 1'b0) begin fails++; $display("FAIL padrst_idle got we%0d w%b exp 0/0", we_cnt - we0, ioctl_wait); end
  endtask

  task automatic test_fresh_load();
    logic [7:0] bv [4] = '{8'h3E, 8'h01, 8'hD3, 8'h00};
    ioctl_download = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      ioctl_wr = 1'b1; ioctl_addr = 25'(i); ioctl_dout = bv[i];
      tick();
      tests++; if (mem_we !== 1'b1 || mem_addr !== AW'(i) || mem_din !== bv[i]) begin fails++; $display("FAIL fresh_wr%0d got we%b a%h d%h exp 1/%h/%h", i, mem_we, mem_addr, mem_din, i, bv[i]); end
    end
    ioctl_wr = 1'b0; ioctl_download = 1'b0;
    tick();
    tests++; if (ioctl_wait !== 1'b1 || cart_size !== 16'd4) begin fails++; $display("FAIL fresh_pad got w%b sz%h exp 1/4", ioctl_wait, cart_size); end
    tick();
    tests++; if (mem_we !== 1'b1 || mem_addr !== AW'(4) || mem_din !== 8'hFF) begin fails++; $display("FAIL fresh_pad_wr got we%b a%h d%h exp 1/4/ff", mem_we, mem_addr, mem_din); end
    tests++; if (cart_sum !== (CSUM ? 16'h0112 : 16'h0)) begin fails++; $display("FAIL fresh_sum got %h exp %h", cart_sum, CSUM ? 16'h0112 : 16'h0); end
  endtask

  initial begin
    for (int i = 0; i < MSZ; i++) begin emem[i] = 8'h00; dmem[i] = 8'h00; end
    test_reset();
    test_basic();
    test_full();
    test_foreign();
    test_zero();
    test_overflow_abort();
    test_reset_in_pad();
    test_fresh_load();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
